ifu_multi: RTL and testbench

IFU_MULTI -- requirements
Module: ifu_multi

---
 rtl/ifu_multi.sv | 237 +++++++++++++++++++++++
 tb/tb_ifu_multi.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_multi.sv
// ifu_multi: multi-instruction fetch unit.
// Issues fetch-group requests to an in-order memory port, tracks up to
// OUTSTANDING requests in a small queue, applies the branch prediction that
// arrives alongside each request, and hands fetched groups downstream.
// Redirects cancel everything in flight. Misaligned PCs and translation faults
// become a single exception group once older work has drained.
// Optional feature: define IFU_IDLE_EN to let idle_req/interrupt gate fetching.
module ifu_multi #(
    parameter int          FW          = 2,
    parameter int          OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC    = 32'h1c000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    input  logic              idle_req,
    input  logic              interrupt,
    output logic              mem_req,
    output logic [31:0]       mem_addr,
    input  logic              mem_addr_ok,
    input  logic [2:0]        mem_count,
    input  logic              mem_tlb_excp,
    input  logic [1:0]        mem_tlb_code,
    input  logic              mem_data_ok,
    input  logic [32*FW-1:0]  mem_rdata,
    input  logic              pred_taken,
    input  logic [1:0]        pred_slot,
    input  logic [31:0]       pred_target,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [2:0]        out_count,
    output logic [31:0]       out_pc,
    output logic [32*FW-1:0]  out_inst,
    output logic              out_excp,
    output logic [1:0]        out_excp_code,
    output logic              out_pred_taken,
    output logic [1:0]        out_pred_slot,
    output logic [31:0]       out_pred_target
);

    localparam int          PTRW     = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam logic [31:0] NOP_INST = 32'h03400000;

    // Fetch control: normal fetching, exception waiting for older groups to
    // drain, and stopped after the exception group has been handed out.
    typedef enum logic [1:0] {
        ST_FETCH     = 2'd0,
        ST_EXCP_PEND = 2'd1,
        ST_STOPPED   = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] fetch_pc;
    logic [1:0]  excp_code_q;
    logic        idle_q;

    // In-order tracking queue: one slot per outstanding memory request.
    logic [31:0]            q_pc          [OUTSTANDING];
    logic [2:0]             q_n           [OUTSTANDING];
    logic [1:0]             q_pred_slot   [OUTSTANDING];
    logic [31:0]            q_pred_target [OUTSTANDING];
    logic [OUTSTANDING-1:0] q_pred_taken;
    logic [OUTSTANDING-1:0] q_vld;
    logic [OUTSTANDING-1:0] q_cancel;
    logic [PTRW-1:0]        head;
    logic [PTRW-1:0]        tail;
    logic [2:0]             inflight;

    logic        aligned;
    logic        live_pending;
    logic        fetch_allowed;
    logic        push;
    logic        pop;
    logic        data_fire;
    logic        excp_fire;
    logic        excp_detect;
    logic        pred_hit;
    logic [2:0]  slot_plus1;
    logic [2:0]  push_n;
    logic [31:0] next_pc;

    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        if (p == PTRW'(OUTSTANDING - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign aligned       = (fetch_pc[1:0] == 2'b00);
    assign live_pending  = |(q_vld & ~q_cancel);
    assign fetch_allowed = !reset && (state == ST_FETCH) && !redirect_valid && !idle_q;

    assign mem_addr = fetch_pc;
    assign mem_req  = fetch_allowed && out_ready && (inflight < 3'(OUTSTANDING))
                      && aligned && !mem_tlb_excp;

    assign push = mem_req && mem_addr_ok;
    // A response with nothing tracked is dropped without touching the queue.
    assign pop  = !reset && mem_data_ok && q_vld[head];

    assign data_fire   = pop && !q_cancel[head] && !redirect_valid;
    assign excp_fire   = !reset && (state == ST_EXCP_PEND) && !live_pending && !redirect_valid;
    assign excp_detect = fetch_allowed && (!aligned || mem_tlb_excp);

    // The group is cut after the predicted-taken slot, but never grows past
    // what the memory actually returns; a prediction beyond the returned words
    // is ignored and fetch continues sequentially.
    assign slot_plus1 = {1'b0, pred_slot} + 3'd1;
    assign pred_hit   = pred_taken && ({1'b0, pred_slot} < mem_count);
    assign push_n     = pred_taken ? ((slot_plus1 < mem_count) ? slot_plus1 : mem_count)
                                   : mem_count;
    assign next_pc    = pred_hit ? pred_target : fetch_pc + {27'd0, mem_count, 2'b00};

    // Output group: a live response takes the slot; otherwise a pending
    // exception is emitted once nothing older is still live.
    always_comb begin
        out_valid       = 1'b0;
        out_count       = 3'd0;
        out_pc          = 32'd0;
        out_inst        = '0;
        out_excp        = 1'b0;
        out_excp_code   = 2'd0;
        out_pred_taken  = 1'b0;
        out_pred_slot   = 2'd0;
        out_pred_target = 32'd0;
        if (data_fire) begin
            out_valid       = 1'b1;
            out_count       = q_n[head];
            out_pc          = q_pc[head];
            out_inst        = mem_rdata;
            out_pred_taken  = q_pred_taken[head];
            out_pred_slot   = q_pred_slot[head];
            out_pred_target = q_pred_target[head];
        end else if (excp_fire) begin
            out_valid      = 1'b1;
            out_count      = 3'd1;
            out_pc         = fetch_pc;
            out_inst[31:0] = NOP_INST;
            out_excp       = 1'b1;
            out_excp_code  = excp_code_q;
        end
    end

`ifdef IFU_IDLE_EN
    // Idle flag: idle_req sets it (and wins over a simultaneous interrupt).
    always_ff @(posedge clk) begin
        if (reset) begin
            idle_q <= 1'b0;
        end else if (idle_req) begin
            idle_q <= 1'b1;
        end else if (interrupt) begin
            idle_q <= 1'b0;
        end
    end
`else
    logic unused_idle_inputs;
    assign idle_q             = 1'b0;
    assign unused_idle_inputs = idle_req | interrupt;
`endif

    // Queue bookkeeping: occupancy, pointers and cancel marks.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_vld    <= '0;
            q_cancel <= '0;
            head     <= '0;
            tail     <= '0;
            inflight <= 3'd0;
        end else begin
            if (redirect_valid) begin
                q_cancel <= '1;
            end
            if (push) begin
                q_vld[tail]    <= 1'b1;
                q_cancel[tail] <= 1'b0;
                tail           <= ptr_inc(tail);
            end
            if (pop) begin
                q_vld[head] <= 1'b0;
                head        <= ptr_inc(head);
            end
            case ({push, pop})
                2'b10:   inflight <= inflight + 3'd1;
                2'b01:   inflight <= inflight - 3'd1;
                default: inflight <= inflight;
            endcase
        end
    end

    // Queue payload captured with each accepted request.
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[tail]          <= fetch_pc;
            q_n[tail]           <= push_n;
            q_pred_taken[tail]  <= pred_taken;
            q_pred_slot[tail]   <= pred_slot;
            q_pred_target[tail] <= pred_target;
        end
    end

    // Fetch PC and exception control; a redirect overrides everything else.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_FETCH;
            fetch_pc    <= RESET_PC;
            excp_code_q <= 2'd0;
        end else if (redirect_valid) begin
            state       <= ST_FETCH;
            fetch_pc    <= redirect_pc;
            excp_code_q <= 2'd0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (excp_detect) begin
                        state       <= ST_EXCP_PEND;
                        excp_code_q <= aligned ? mem_tlb_code : 2'd0;
                    end else if (push) begin
                        fetch_pc <= next_pc;
                    end
                end
                ST_EXCP_PEND: begin
                    if (excp_fire) begin
                        state <= ST_STOPPED;
                    end
                end
                ST_STOPPED: begin
                    state <= ST_STOPPED;
                end
                default: begin
                    state <= ST_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_multi.sv
// tb_ifu_multi: directed scenarios followed by randomized traffic for
// ifu_multi, checked against a transaction-level model of the fetch unit.
// Honours IFU_IDLE_EN to match the build of the design under test.
`timescale 1ns/1ps
module tb_ifu_multi;

    localparam int          FW          = 2;
    localparam int          OUTSTANDING = 2;
    localparam logic [31:0] RESET_PC    = 32'h1c000000;
    localparam logic [31:0] NOP         = 32'h03400000;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        idle_req;
    logic        interrupt;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_addr_ok;
    logic [2:0]  mem_count;
    logic        mem_tlb_excp;
    logic [1:0]  mem_tlb_code;
    logic        mem_data_ok;
    logic [63:0] mem_rdata;
    logic        pred_taken;
    logic [1:0]  pred_slot;
    logic [31:0] pred_target;
    logic        out_ready;
    logic        out_valid;
    logic [2:0]  out_count;
    logic [31:0] out_pc;
    logic [63:0] out_inst;
    logic        out_excp;
    logic [1:0]  out_excp_code;
    logic        out_pred_taken;
    logic [1:0]  out_pred_slot;
    logic [31:0] out_pred_target;

    always #5 clk = ~clk;

    ifu_multi #(.FW(FW), .OUTSTANDING(OUTSTANDING), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .idle_req(idle_req), .interrupt(interrupt),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_addr_ok(mem_addr_ok),
        .mem_count(mem_count), .mem_tlb_excp(mem_tlb_excp), .mem_tlb_code(mem_tlb_code),
        .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
        .pred_taken(pred_taken), .pred_slot(pred_slot), .pred_target(pred_target),
        .out_ready(out_ready), .out_valid(out_valid), .out_count(out_count),
        .out_pc(out_pc), .out_inst(out_inst), .out_excp(out_excp),
        .out_excp_code(out_excp_code), .out_pred_taken(out_pred_taken),
        .out_pred_slot(out_pred_slot), .out_pred_target(out_pred_target)
    );

    typedef struct {
        logic        reset;
        logic        redirect_valid;
        logic [31:0] redirect_pc;
        logic        idle_req;
        logic        interrupt;
        logic        mem_addr_ok;
        logic [2:0]  mem_count;
        logic        mem_tlb_excp;
        logic [1:0]  mem_tlb_code;
        logic        mem_data_ok;
        logic [63:0] mem_rdata;
        logic        pred_taken;
        logic [1:0]  pred_slot;
        logic [31:0] pred_target;
        logic        out_ready;
    } stim_t;

    typedef struct {
        logic [31:0] pc;
        int          n;
        logic        pt;
        logic [1:0]  ps;
        logic [31:0] tgt;
        bit          cancelled;
    } entry_t;

    int check_count = 0;
    int pass_count  = 0;

    // Reference model: requests in flight as a queue of transactions.
    entry_t      mq[$];
    logic [31:0] m_pc      = RESET_PC;
    bit          m_pending = 0;
    bit          m_stopped = 0;
    bit          m_idle    = 0;
    logic [1:0]  m_code    = 2'd0;

    stim_t       cur;
    bit          e_req, e_valid, e_excp, e_pt;
    logic [1:0]  e_code, e_ps;
    logic [31:0] e_pc, e_tgt;
    int          e_count;
    logic [63:0] e_inst;

    function automatic stim_t quiet();
        stim_t s;
        s.reset = 0; s.redirect_valid = 0; s.redirect_pc = 32'd0;
        s.idle_req = 0; s.interrupt = 0; s.mem_addr_ok = 0; s.mem_count = 3'd2;
        s.mem_tlb_excp = 0; s.mem_tlb_code = 2'd0; s.mem_data_ok = 0; s.mem_rdata = 64'd0;
        s.pred_taken = 0; s.pred_slot = 2'd0; s.pred_target = 32'd0; s.out_ready = 1;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s = quiet();
        s.redirect_valid = ($urandom_range(0, 11) == 0);
        s.redirect_pc    = 32'h1c000000 + ($urandom_range(0, 255) << 2);
        if ($urandom_range(0, 7) == 0) s.redirect_pc[1:0] = 2'($urandom_range(1, 3));
        s.idle_req     = ($urandom_range(0, 19) == 0);
        s.interrupt    = ($urandom_range(0, 3) == 0);
        s.mem_addr_ok  = ($urandom_range(0, 3) != 0);
        s.mem_count    = 3'($urandom_range(1, FW));
        s.mem_tlb_excp = ($urandom_range(0, 39) == 0);
        s.mem_tlb_code = 2'($urandom_range(1, 3));
        s.mem_data_ok  = ($urandom_range(0, 1) == 1);
        s.mem_rdata    = {$urandom, $urandom};
        s.pred_taken   = ($urandom_range(0, 3) == 0);
        s.pred_slot    = 2'($urandom_range(0, 3));
        s.pred_target  = 32'h1c000000 + ($urandom_range(0, 255) << 2);
        s.out_ready    = ($urandom_range(0, 7) != 0);
        return s;
    endfunction

    function automatic bit idle_active();
`ifdef IFU_IDLE_EN
        return m_idle;
`else
        return 0;
`endif
    endfunction

    function automatic bit has_live();
        foreach (mq[i]) if (!mq[i].cancelled) return 1;
        return 0;
    endfunction

    function automatic bit fetch_blocked();
        return m_pending || m_stopped || cur.redirect_valid || idle_active();
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        check_count++;
        assert (obs === exp) pass_count++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic computeExpected();
        e_req = 0; e_valid = 0; e_excp = 0; e_code = 2'd0; e_pc = 32'd0; e_count = 0;
        e_inst = 64'd0; e_pt = 0; e_ps = 2'd0; e_tgt = 32'd0;
        if (cur.reset) return;
        e_req = cur.out_ready && (mq.size() < OUTSTANDING) && !fetch_blocked()
                && (m_pc[1:0] == 2'b00) && !cur.mem_tlb_excp;
        if (!cur.redirect_valid && cur.mem_data_ok && mq.size() > 0 && !mq[0].cancelled) begin
            e_valid = 1; e_pc = mq[0].pc; e_count = mq[0].n; e_inst = cur.mem_rdata;
            e_pt = mq[0].pt; e_ps = mq[0].ps; e_tgt = mq[0].tgt;
        end else if (!cur.redirect_valid && m_pending && !has_live()) begin
            e_valid = 1; e_excp = 1; e_code = m_code; e_pc = m_pc; e_count = 1;
            e_inst = {32'd0, NOP};
        end
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, ".mem_req"}, 64'(mem_req), 64'(e_req));
        if (e_req) checkOutput({tag, ".mem_addr"}, 64'(mem_addr), 64'(m_pc));
        checkOutput({tag, ".out_valid"}, 64'(out_valid), 64'(e_valid));
        if (cur.reset) checkOutput({tag, ".out_excp_rst"}, 64'(out_excp), 64'd0);
        if (e_valid) begin
            checkOutput({tag, ".out_excp"}, 64'(out_excp), 64'(e_excp));
            checkOutput({tag, ".out_pc"}, 64'(out_pc), 64'(e_pc));
            checkOutput({tag, ".out_count"}, 64'(out_count), 64'(e_count));
            if (e_excp) begin
                checkOutput({tag, ".excp_inst"}, 64'(out_inst[31:0]), 64'(e_inst[31:0]));
                checkOutput({tag, ".excp_code"}, 64'(out_excp_code), 64'(e_code));
            end else begin
                checkOutput({tag, ".out_inst"}, out_inst, e_inst);
                checkOutput({tag, ".pred_taken"}, 64'(out_pred_taken), 64'(e_pt));
                checkOutput({tag, ".pred_slot"}, 64'(out_pred_slot), 64'(e_ps));
                checkOutput({tag, ".pred_target"}, 64'(out_pred_target), 64'(e_tgt));
            end
        end
    endtask

    task automatic applyStimulus(input stim_t s, input string tag);
        @(negedge clk);
        cur = s;
        reset = s.reset; redirect_valid = s.redirect_valid; redirect_pc = s.redirect_pc;
        idle_req = s.idle_req; interrupt = s.interrupt; mem_addr_ok = s.mem_addr_ok;
        mem_count = s.mem_count; mem_tlb_excp = s.mem_tlb_excp; mem_tlb_code = s.mem_tlb_code;
        mem_data_ok = s.mem_data_ok; mem_rdata = s.mem_rdata; pred_taken = s.pred_taken;
        pred_slot = s.pred_slot; pred_target = s.pred_target; out_ready = s.out_ready;
        #1;
        computeExpected();
        checkModel(tag);
    endtask

    task automatic updateModel();
        bit blocked;
        entry_t e;
        int     cnt;
        int     slot1;
        if (cur.reset) begin
            mq.delete(); m_pc = RESET_PC; m_pending = 0; m_stopped = 0; m_idle = 0; m_code = 2'd0;
            return;
        end
        blocked = fetch_blocked();
        cnt     = int'(cur.mem_count);
        if (cur.redirect_valid) begin
            foreach (mq[i]) mq[i].cancelled = 1;
            if (cur.mem_data_ok && mq.size() > 0) void'(mq.pop_front());
            m_pc = cur.redirect_pc; m_pending = 0; m_stopped = 0;
        end else begin
            if (e_valid && e_excp) begin
                m_pending = 0; m_stopped = 1;
            end
            if (cur.mem_data_ok && mq.size() > 0) void'(mq.pop_front());
            if (e_req && cur.mem_addr_ok) begin
                slot1 = int'(cur.pred_slot) + 1;
                e.pc = m_pc; e.pt = cur.pred_taken; e.ps = cur.pred_slot;
                e.tgt = cur.pred_target; e.cancelled = 0;
                e.n = cur.pred_taken ? ((slot1 < cnt) ? slot1 : cnt) : cnt;
                mq.push_back(e);
                if (cur.pred_taken && int'(cur.pred_slot) < cnt) m_pc = cur.pred_target;
                else m_pc = m_pc + 32'(4 * cnt);
            end else if (!blocked && (m_pc[1:0] != 2'b00 || cur.mem_tlb_excp)) begin
                m_pending = 1;
                m_code    = (m_pc[1:0] != 2'b00) ? 2'd0 : cur.mem_tlb_code;
            end
        end
        if (cur.idle_req) m_idle = 1;
        else if (cur.interrupt) m_idle = 0;
    endtask

    task automatic advance();
        updateModel();
        @(posedge clk);
    endtask

    stim_t       s;
    int          groups;
    logic [31:0] g_pc   [2];
    bit          g_excp [2];
    logic [1:0]  g_code [2];
    logic [31:0] g_inst [2];

    initial begin
        // Reset with a stray response on the port: nothing may come out.
        s = quiet(); s.reset = 1; s.mem_data_ok = 1; s.mem_addr_ok = 1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(s, "rst"); advance();
        end

        // Sequential fetch, two groups in flight, in-order responses.
        s = quiet(); s.mem_addr_ok = 1;
        applyStimulus(s, "s1.req0");
        checkOutput("s1.addr0", 64'(mem_addr), 64'h1c000000);
        checkOutput("s1.req0_on", 64'(mem_req), 64'd1);
        advance();
        applyStimulus(s, "s1.req1");
        checkOutput("s1.addr1", 64'(mem_addr), 64'h1c000008);
        advance();
        s = quiet(); s.mem_data_ok = 1; s.mem_rdata = 64'h22222222_11111111;
        applyStimulus(s, "s1.rsp0");
        checkOutput("s1.rsp0_pc", 64'(out_pc), 64'h1c000000);
        checkOutput("s1.rsp0_cnt", 64'(out_count), 64'd2);
        checkOutput("s1.full", 64'(mem_req), 64'd0);
        advance();
        s.mem_rdata = 64'h44444444_33333333;
        applyStimulus(s, "s1.rsp1");
        checkOutput("s1.rsp1_pc", 64'(out_pc), 64'h1c000008);
        checkOutput("s1.rsp1_cnt", 64'(out_count), 64'd2);
        advance();
        applyStimulus(s, "s1.empty_rsp");
        checkOutput("s1.empty_valid", 64'(out_valid), 64'd0);
        advance();

        // Taken prediction in slot 0 truncates the group and steers fetch.
        s = quiet(); s.redirect_valid = 1; s.redirect_pc = 32'h1c000000;
        applyStimulus(s, "s2.redir"); advance();
        s = quiet(); s.mem_addr_ok = 1; s.pred_taken = 1; s.pred_slot = 2'd0;
        s.pred_target = 32'h1c000100;
        applyStimulus(s, "s2.req"); advance();
        s = quiet(); s.mem_data_ok = 1; s.mem_rdata = 64'h0badf00d_12345678;
        applyStimulus(s, "s2.rsp");
        checkOutput("s2.cnt", 64'(out_count), 64'd1);
        checkOutput("s2.next_addr", 64'(mem_addr), 64'h1c000100);
        checkOutput("s2.pt", 64'(out_pred_taken), 64'd1);
        advance();

        // Redirect with two in flight: both responses are dropped.
        s = quiet(); s.mem_addr_ok = 1;
        applyStimulus(s, "s3.req0"); advance();
        applyStimulus(s, "s3.req1"); advance();
        s = quiet(); s.redirect_valid = 1; s.redirect_pc = 32'h1c000200; s.mem_data_ok = 1;
        applyStimulus(s, "s3.redir");
        checkOutput("s3.drop0", 64'(out_valid), 64'd0);
        advance();
        s = quiet(); s.mem_data_ok = 1;
        applyStimulus(s, "s3.rsp1");
        checkOutput("s3.drop1", 64'(out_valid), 64'd0);
        checkOutput("s3.next_addr", 64'(mem_addr), 64'h1c000200);
        checkOutput("s3.next_req", 64'(mem_req), 64'd1);
        advance();

        // Misaligned redirect target: one ADEF group, then fetch stays stopped.
        s = quiet(); s.redirect_valid = 1; s.redirect_pc = 32'h1c000002;
        applyStimulus(s, "s4.redir"); advance();
        groups = 0;
        for (int i = 0; i < 6; i++) begin
            s = quiet(); s.mem_addr_ok = 1;
            applyStimulus(s, "s4.wait");
            checkOutput("s4.no_req", 64'(mem_req), 64'd0);
            if (out_valid && groups < 2) begin
                g_pc[groups] = out_pc; g_excp[groups] = out_excp;
                g_code[groups] = out_excp_code; g_inst[groups] = out_inst[31:0];
            end
            if (out_valid) groups++;
            advance();
        end
        checkOutput("s4.groups", 64'(groups), 64'd1);
        if (groups >= 1) begin
            checkOutput("s4.excp", 64'(g_excp[0]), 64'd1);
            checkOutput("s4.code", 64'(g_code[0]), 64'd0);
            checkOutput("s4.inst", 64'(g_inst[0]), 64'(NOP));
            checkOutput("s4.pc", 64'(g_pc[0]), 64'h1c000002);
        end

        // Translation fault behind an in-flight request: data first, then PIF.
        s = quiet(); s.redirect_valid = 1; s.redirect_pc = 32'h1c000300;
        applyStimulus(s, "s5.redir"); advance();
        s = quiet(); s.mem_addr_ok = 1;
        applyStimulus(s, "s5.req"); advance();
        s = quiet(); s.mem_tlb_excp = 1; s.mem_tlb_code = 2'd2; s.mem_addr_ok = 1;
        applyStimulus(s, "s5.tlb");
        checkOutput("s5.tlb_noreq", 64'(mem_req), 64'd0);
        advance();
        groups = 0;
        for (int i = 0; i < 4; i++) begin
            s = quiet(); s.mem_data_ok = 1; s.mem_rdata = 64'h55555555_66666666;
            applyStimulus(s, "s5.drain");
            if (out_valid && groups < 2) begin
                g_pc[groups] = out_pc; g_excp[groups] = out_excp;
                g_code[groups] = out_excp_code; g_inst[groups] = out_inst[31:0];
            end
            if (out_valid) groups++;
            advance();
        end
        checkOutput("s5.groups", 64'(groups), 64'd2);
        if (groups >= 2) begin
            checkOutput("s5.first_data", 64'(g_excp[0]), 64'd0);
            checkOutput("s5.first_pc", 64'(g_pc[0]), 64'h1c000300);
            checkOutput("s5.second_excp", 64'(g_excp[1]), 64'd1);
            checkOutput("s5.second_code", 64'(g_code[1]), 64'd2);
            checkOutput("s5.second_pc", 64'(g_pc[1]), 64'h1c000308);
        end

        // Idle handling.
        s = quiet(); s.redirect_valid = 1; s.redirect_pc = 32'h1c000400;
        applyStimulus(s, "s6.redir"); advance();
        s = quiet(); s.idle_req = 1; s.interrupt = 1;
        applyStimulus(s, "s6.idle"); advance();
`ifdef IFU_IDLE_EN
        for (int i = 0; i < 3; i++) begin
            s = quiet(); s.mem_addr_ok = 1;
            applyStimulus(s, "s6.idling");
            checkOutput("s6.idle_noreq", 64'(mem_req), 64'd0);
            advance();
        end
        s = quiet(); s.interrupt = 1;
        applyStimulus(s, "s6.irq"); advance();
`endif
        s = quiet(); s.mem_addr_ok = 1;
        applyStimulus(s, "s6.resume");
        checkOutput("s6.resume_req", 64'(mem_req), 64'd1);
        checkOutput("s6.resume_addr", 64'(mem_addr), 64'h1c000400);
        advance();
        s = quiet(); s.mem_data_ok = 1;
        applyStimulus(s, "s6.drain"); advance();

        // Randomized traffic with a reset dropped into the middle.
        for (int i = 0; i < 800; i++) begin
            s = rand_stim();
            if (i == 400 || i == 401) s.reset = 1;
            applyStimulus(s, "rnd");
            advance();
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
